// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, reserved-op range and FSM state type shared by alu_seq.
package alu_seq_pkg;
  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_OR    = 4'h1;
  localparam logic [3:0] OP_XOR   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_ROL   = 4'h4;
  localparam logic [3:0] OP_SLL   = 4'h5;
  localparam logic [3:0] OP_ROR   = 4'h6;
  localparam logic [3:0] OP_SRL   = 4'h7;
  localparam logic [3:0] OP_SRA   = 4'h8;
  localparam logic [3:0] OP_SLT   = 4'h9;
  localparam logic [3:0] OP_SEQ   = 4'hA;
  localparam logic [3:0] OP_PASSB = 4'hB;
  localparam logic [3:0] OP_MUL   = 4'hC;
  localparam logic [3:0] OP_RSV_LO = 4'hD;
  localparam logic [3:0] OP_RSV_HI = 4'hF;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: radix-2 shift-add unsigned multiplier, WIDTH iterations after start.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);
  localparam int CW = $clog2(WIDTH);
  logic [2*WIDTH-1:0] mc;
  logic [WIDTH-1:0]   mp;
  logic [CW-1:0]      cnt;
  logic               run;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mc <= '0;
      mp <= '0;
      prod <= '0;
      cnt <= '0;
      run <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      mc <= {{WIDTH{1'b0}}, a};
      mp <= b;
      prod <= '0;
      cnt <= CW'(WIDTH - 1);
      run <= 1'b1;
      done <= 1'b0;
    end else if (run) begin
      prod <= prod + (mp[0] ? mc : '0);
      mc <= mc << 1;
      mp <= mp >> 1;
      cnt <= cnt - 1'b1;
      run <= cnt != '0;
      done <= cnt == '0;
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: valid/ready ALU with registered Out/Ofl/Z/Err.
// Iterative signed/unsigned MUL present only when ALU_SEQ_MUL_EN is defined.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic [3:0]       Op,
  input  logic             invA,
  input  logic             invB,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             Ofl,
  output logic             Z,
  output logic             Err,
  output logic             busy
);
  localparam int SW = $clog2(WIDTH);
  logic [WIDTH-1:0] opa, opb, res, sra, mul_res;
  logic [SW-1:0]    sh;
  logic [WIDTH:0]   sum;
  logic             alu_ofl, alu_err, mul_ofl, mul_load, m_start, accept, load;
  state_t           state;
  assign opa = invA ? ~A : A;
  assign opb = invB ? ~B : B;
  assign sh = opb[SW-1:0];
  assign sum = {1'b0, opa} + {1'b0, opb} + (WIDTH + 1)'(Cin);
  assign sra = $signed(opa) >>> sh;
  always_comb begin
    res = '0;
    alu_ofl = 1'b0;
    alu_err = 1'b0;
    case (Op)
      OP_ADD: begin
        res = sum[WIDTH-1:0];
        alu_ofl = sign ? (opa[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]) : sum[WIDTH];
      end
      OP_OR:    res = opa | opb;
      OP_XOR:   res = opa ^ opb;
      OP_AND:   res = opa & opb;
      OP_ROL:   res = (opa << sh) | (opa >> (WIDTH - 32'(sh)));
      OP_SLL:   res = opa << sh;
      OP_ROR:   res = (opa >> sh) | (opa << (WIDTH - 32'(sh)));
      OP_SRL:   res = opa >> sh;
      OP_SRA:   res = sign ? sra : opa >> sh;
      OP_SLT:   res = WIDTH'(sign ? ($signed(opa) < $signed(opb)) : (opa < opb));
      OP_SEQ:   res = WIDTH'(opa == opb);
      OP_PASSB: res = opb;
      default:  alu_err = 1'b1;
    endcase
  end
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0]   ma, mb;
  logic [2*WIDTH-1:0] m_prod, m_p;
  logic               m_done, m_neg, m_sign;
  state_t             state_n;
  assign m_start = accept && Op == OP_MUL;
  assign ma = (sign && opa[WIDTH-1]) ? -opa : opa;
  assign mb = (sign && opb[WIDTH-1]) ? -opb : opb;
  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk(clk), .rst(rst), .start(m_start), .a(ma), .b(mb), .done(m_done), .prod(m_prod)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_IDLE;
      m_neg <= 1'b0;
      m_sign <= 1'b0;
    end else begin
      state <= state_n;
      if (m_start) begin
        m_neg <= sign && (opa[WIDTH-1] ^ opb[WIDTH-1]);
        m_sign <= sign;
      end
    end
  assign m_p = m_neg ? -m_prod : m_prod;
  assign mul_res = m_p[WIDTH-1:0];
  assign mul_ofl = m_sign ? m_p[2*WIDTH-1:WIDTH] != {WIDTH{m_p[WIDTH-1]}} : m_p[2*WIDTH-1:WIDTH] != '0;
  always_comb begin
    state_n = state;
    mul_load = 1'b0;
    case (state)
      S_IDLE: state_n = m_start ? S_MUL : S_IDLE;
      S_MUL: if (m_done) begin
        mul_load = !(out_valid && !out_ready);
        state_n = mul_load ? S_IDLE : S_HOLD;
      end
      S_HOLD: begin
        mul_load = !out_valid || out_ready;
        state_n = mul_load ? S_IDLE : S_HOLD;
      end
      default: state_n = S_IDLE;
    endcase
  end
  assign busy = state == S_MUL;
`else
  assign state = S_IDLE;
  assign m_start = 1'b0;
  assign mul_load = 1'b0;
  assign mul_res = '0;
  assign mul_ofl = 1'b0;
  assign busy = 1'b0;
`endif
  assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  assign load = (accept && !m_start) || mul_load;
  // A freshly loaded result wins over a same-cycle consume.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      out_valid <= 1'b0;
      Out <= '0;
      Ofl <= 1'b0;
      Z <= 1'b1;
      Err <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      Out <= mul_load ? mul_res : res;
      Ofl <= mul_load ? mul_ofl : alu_ofl;
      Z <= (mul_load ? mul_res : res) == '0;
      Err <= !mul_load && alu_err;
    end else if (out_ready) out_valid <= 1'b0;
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 16-bit combinational ALU. It accepts one operation per valid/ready transfer and returns a registered result with Ofl/Z/Err flags. All single-cycle ops complete with 1-cycle latency; an optional iterative multiply takes WIDTH+1 cycles. It sits between the decode/execute register and the writeback path of the pipelined datapath, and backpressures decode while busy.

## Interface
- WIDTH, 16, datapath width; power of two, ≥4
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  operand/op bundle valid
- in_ready  out  1  block can accept this cycle
- A, B  in  WIDTH  operands
- Cin  in  1  carry-in, ADD only
- Op  in  4  opcode
- invA, invB  in  1  bitwise-invert operand before use
- sign  in  1  1 = two's-complement semantics for Ofl/SLT/SRA/MUL
- out_valid  out  1  result registers valid
- out_ready  in  1  consumer takes result
- Out  out  WIDTH  result
- Ofl  out  1  overflow/carry flag
- Z  out  1  Out == 0
- Err  out  1  reserved opcode (or MUL compiled out)
- busy  out  1  multiply in progress

## Operation
- a = invA ? ~A : A; b = invB ? ~B : B; sh = b[log2(WIDTH)-1:0].
- Opcodes: 0 ADD (a+b+Cin), 1 OR, 2 XOR, 3 AND, 4 ROL a by sh, 5 SLL, 6 ROR, 7 SRL, 8 SRA, 9 SLT (Out=1 if a<b, signed per sign), A SEQ (Out=1 if a==b), B PASSB (b), C MUL (low WIDTH of a*b), D–F reserved.
- Ofl: ADD with sign=1 → operand signs equal and result sign differs; sign=0 → carry out. MUL → high half of 2·WIDTH product not a zero-/sign-extension of low half. All other ops Ofl=0.
- Reserved op: Out=0, Ofl=0, Z=1, Err=1, 1-cycle latency.
- FSM: IDLE, MUL, HOLD.
  - IDLE: accept when in_valid&&in_ready. Non-MUL → result regs loaded, out_valid=1, stay IDLE. MUL → latch a, b, sign; go MUL.
  - MUL: WIDTH shift-add iterations, counter WIDTH-1 down to 0; at 0 load result, out_valid=1, go IDLE. busy=1 throughout MUL.
  - HOLD is entered instead of IDLE if a MUL completes while out_valid&&!out_ready is still pending; MUL waits in HOLD until slot frees, then loads.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- out_valid clears on out_valid&&out_ready unless a new result loads the same cycle (back-to-back allowed; new result wins).
- Result regs stable while out_valid&&!out_ready.
- Signed MUL: magnitudes multiplied, 2·WIDTH product negated when operand signs differ.

## Timing
- Reset (rst=0, async): state=IDLE, out_valid=0, Out=0, Ofl=0, Z=1, Err=0, busy=0, counter=0; in_ready=1 after release.
- Single-cycle op accepted at edge n → out_valid at n+1.
- MUL accepted at edge n → busy n+1..n+WIDTH, out_valid at n+WIDTH+1 (17 cycles at WIDTH=16).
- Reset mid-MUL: aborts immediately, no result produced.
- Inputs ignored when in_ready=0; no combinational path from in_valid to out_valid; in_ready depends on out_ready combinationally.

## Configuration
- ALU_SEQ_MUL_EN defined: MUL op, MUL/HOLD states, busy, iteration counter present.
- Undefined: Op C treated as reserved (Err=1, 1-cycle); busy tied 0; FSM reduces to IDLE only.

## Structure
- Package alu_seq_pkg: opcode localparams (OP_ADD…OP_MUL), FSM state typedef, reserved-op range.
- Sub-module alu_mul_iter: radix-2 shift-add unsigned multiplier (start, done, WIDTH-parametrised, 2·WIDTH product); instantiated only under ALU_SEQ_MUL_EN.

## Test plan
- WIDTH=16, ADD A=7FFF B=0001 Cin=0 sign=1 → Out=8000, Ofl=1, Z=0, out_valid next cycle.
- ADD A=FFFF B=0001 sign=0 → Out=0000, Ofl=1, Z=1; same with invB=1 (b=FFFE) → Out=FFFD, Ofl=1.
- ROR A=0001 B=0001 → 8000; SRA A=8000 B=0004 → F800; SLT A=FFFF B=0001 sign=1 → 1, sign=0 → 0.
- MUL A=0100 B=0100 sign=0 → Out=0000, Ofl=1 after 17 cycles, in_ready=0 and busy=1 meanwhile; MUL A=FFFE B=0003 sign=1 → FFFA, Ofl=0.
- out_ready held 0 for 5 cycles after ADD result → Out stable, in_ready=0; then back-to-back ADDs with out_ready=1 → one result per cycle.
- Assert rst mid-MUL at cycle 8 → out_valid=0, busy=0, Z=1 immediately; Op=E → Err=1, Out=0.
